// File: rtl/division_rom_writer_pkg.sv
// Shared constants for the division table: entry layout, K range and the
// 10^K / 10^K+1 lookup tables also used by the solver.
package division_rom_writer_pkg;

   localparam int unsigned K_MAX       = 12;
   localparam int unsigned ENTRY_COUNT = 468;
   localparam int unsigned ADDR_W      = 10;
   localparam int unsigned XW          = 40;
   localparam int unsigned CW          = 41;
   localparam int unsigned ENTRY_W     = 96;

   localparam int unsigned XS_LSB    = 0;
   localparam int unsigned XE_LSB    = 40;
   localparam int unsigned VALID_BIT = 80;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_DIV_LO,
      S_DIV_HI,
      S_CLAMP,
      S_WRITE,
      S_DONE
   } state_t;

   function automatic logic [XW-1:0] pow10(input logic [3:0] k);
      case (k)
         4'd0:    pow10 = 40'd1;
         4'd1:    pow10 = 40'd10;
         4'd2:    pow10 = 40'd100;
         4'd3:    pow10 = 40'd1000;
         4'd4:    pow10 = 40'd10000;
         4'd5:    pow10 = 40'd100000;
         4'd6:    pow10 = 40'd1000000;
         4'd7:    pow10 = 40'd10000000;
         4'd8:    pow10 = 40'd100000000;
         4'd9:    pow10 = 40'd1000000000;
         4'd10:   pow10 = 40'd10000000000;
         4'd11:   pow10 = 40'd100000000000;
         4'd12:   pow10 = 40'd1000000000000;
         default: pow10 = 40'd0;
      endcase
   endfunction

   // Repeated-half multiplier divisor: ID = x * (10^K + 1)
   function automatic logic [CW-1:0] const_k(input logic [3:0] k);
      const_k = {1'b0, pow10(k)} + 41'd1;
   endfunction

endpackage

// File: rtl/division_rom_writer_div40_seq.sv
// Restoring radix-2 divider: 1 load cycle then 40 iterations, div_done pulses
// for one cycle with quotient/remainder final.
module div40_seq
   import division_rom_writer_pkg::*;
(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic [XW-1:0] dividend,
   input  logic [CW-1:0] divisor,
   output logic [XW-1:0] quotient,
   output logic [CW-1:0] remainder,
   output logic          div_done
);

   logic [5:0]  cnt;
   logic        busy;
   logic [CW:0] trial;
   logic [CW:0] diff;

   always_comb begin
      trial = {remainder, quotient[XW-1]};
      diff  = trial - {1'b0, divisor};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         quotient  <= '0;
         remainder <= '0;
         cnt       <= '0;
         busy      <= 1'b0;
         div_done  <= 1'b0;
      end else begin
         div_done <= 1'b0;
         if (start) begin
            quotient  <= dividend;
            remainder <= '0;
            cnt       <= 6'd40;
            busy      <= 1'b1;
         end else if (busy) begin
            if (trial >= {1'b0, divisor}) begin
               remainder <= diff[CW-1:0];
               quotient  <= {quotient[XW-2:0], 1'b1};
            end else begin
               remainder <= trial[CW-1:0];
               quotient  <= {quotient[XW-2:0], 1'b0};
            end
            cnt <= cnt - 6'd1;
            if (cnt == 6'd1) begin
               busy     <= 1'b0;
               div_done <= 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/division_rom_writer.sv
// Streams ID ranges in and writes one (x_start, x_end, valid) entry per
// (range, K) into the division memory.
module division_rom_writer
   import division_rom_writer_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [XW-1:0]        in_lo,
   input  logic [XW-1:0]        in_hi,
   input  logic                 in_last,
   output logic                 wr_en,
   output logic [ADDR_W-1:0]    wr_addr,
   output logic [ENTRY_W-1:0]   wr_data,
   output logic [ADDR_W-1:0]    entries_written,
   output logic                 overflow,
   output logic                 done
);

   state_t              state, state_n;
   logic [3:0]          k, k_n;
   logic [XW-1:0]       lo_r, lo_n, hi_r, hi_n;
   logic                last_r, last_n;
   logic [XW-1:0]       q_lo, q_lo_n, q_hi, q_hi_n;
   logic                in_ready_n, wr_en_n, overflow_n, done_n;
   logic [ADDR_W-1:0]   wr_addr_n, entries_n;
   logic [ENTRY_W-1:0]  wr_data_n;

   logic                div_start_c;
   logic [XW-1:0]       div_dividend_c;
   logic [CW-1:0]       div_divisor_c;
   logic [XW-1:0]       quotient;
   logic [CW-1:0]       remainder;
   logic                div_done;
   logic [XW-1:0]       lo_min_c, hi_max_c, x_start_c, x_end_c;
   logic                full_c;

   div40_seq u_div (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (div_start_c),
      .dividend  (div_dividend_c),
      .divisor   (div_divisor_c),
      .quotient  (quotient),
      .remainder (remainder),
      .div_done  (div_done)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= S_IDLE;
         k               <= '0;
         lo_r            <= '0;
         hi_r            <= '0;
         last_r          <= 1'b0;
         q_lo            <= '0;
         q_hi            <= '0;
         in_ready        <= 1'b0;
         wr_en           <= 1'b0;
         wr_addr         <= '0;
         wr_data         <= '0;
         entries_written <= '0;
         overflow        <= 1'b0;
         done            <= 1'b0;
      end else begin
         state           <= state_n;
         k               <= k_n;
         lo_r            <= lo_n;
         hi_r            <= hi_n;
         last_r          <= last_n;
         q_lo            <= q_lo_n;
         q_hi            <= q_hi_n;
         in_ready        <= in_ready_n;
         wr_en           <= wr_en_n;
         wr_addr         <= wr_addr_n;
         wr_data         <= wr_data_n;
         entries_written <= entries_n;
         overflow        <= overflow_n;
         done            <= done_n;
      end
   end

   always_comb begin
      state_n        = state;
      k_n            = k;
      lo_n           = lo_r;
      hi_n           = hi_r;
      last_n         = last_r;
      q_lo_n         = q_lo;
      q_hi_n         = q_hi;
      wr_en_n        = 1'b0;
      wr_addr_n      = wr_addr;
      wr_data_n      = wr_data;
      entries_n      = entries_written;
      overflow_n     = overflow;
      done_n         = done;
      div_start_c    = 1'b0;
      div_dividend_c = lo_r;
      div_divisor_c  = const_k(k);
      lo_min_c       = pow10(k - 4'd1);
      hi_max_c       = pow10(k) - 40'd1;
      x_start_c      = (q_lo < lo_min_c) ? lo_min_c : q_lo;
      x_end_c        = (q_hi > hi_max_c) ? hi_max_c : q_hi;
      full_c         = (32'(entries_written) + K_MAX) > ENTRY_COUNT;

      case (state)
         S_IDLE: begin
            if (in_valid && in_ready) begin
               lo_n    = in_lo;
               hi_n    = in_hi;
               last_n  = in_last;
               k_n     = 4'd1;
               state_n = S_SETUP;
            end else if (in_valid && full_c) begin
               overflow_n = 1'b1;
            end
         end
         S_SETUP: begin
            div_start_c    = 1'b1;
            div_dividend_c = lo_r;
            state_n        = S_DIV_LO;
         end
         S_DIV_LO: begin
            if (div_done) begin
               // Ceiling of lo / c
               q_lo_n         = quotient + XW'(remainder != '0);
               div_start_c    = 1'b1;
               div_dividend_c = hi_r;
               state_n        = S_DIV_HI;
            end
         end
         S_DIV_HI: begin
            if (div_done) begin
               q_hi_n  = quotient;
               state_n = S_CLAMP;
            end
         end
         S_CLAMP: begin
            wr_en_n   = 1'b1;
            wr_data_n = '0;
            if (x_start_c <= x_end_c) begin
               wr_data_n[XS_LSB +: XW] = x_start_c;
               wr_data_n[XE_LSB +: XW] = x_end_c;
               wr_data_n[VALID_BIT]    = 1'b1;
            end
            state_n = S_WRITE;
         end
         S_WRITE: begin
            wr_addr_n = wr_addr + ADDR_W'(1);
            entries_n = entries_written + ADDR_W'(1);
            if (k < 4'(K_MAX)) begin
               k_n     = k + 4'd1;
               state_n = S_SETUP;
            end else if (last_r) begin
               done_n  = 1'b1;
               state_n = S_DONE;
            end else begin
               state_n = S_IDLE;
            end
         end
         S_DONE: begin
            state_n = S_DONE;
         end
         default: state_n = S_IDLE;
      endcase

      in_ready_n = (state_n == S_IDLE) && !done_n &&
                   ((32'(entries_n) + K_MAX) <= ENTRY_COUNT);
   end

endmodule

// File: tb/tb_division_rom_writer.sv
// Directed bench for division_rom_writer: expected table entries are worked
// out by hand from the ID ranges.
module tb_division_rom_writer;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [39:0]  in_lo = '0;
   logic [39:0]  in_hi = '0;
   logic         in_last = 1'b0;
   logic         wr_en;
   logic [9:0]   wr_addr;
   logic [95:0]  wr_data;
   logic [9:0]   entries_written;
   logic         overflow;
   logic         done;

   int vectors = 0;
   int miscompares = 0;

   logic [95:0]  mem [0:1023];
   int           wr_cnt = 0;
   logic [9:0]   last_wr_addr = '0;

   always #5 clk = ~clk;

   division_rom_writer dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .in_valid        (in_valid),
      .in_ready        (in_ready),
      .in_lo           (in_lo),
      .in_hi           (in_hi),
      .in_last         (in_last),
      .wr_en           (wr_en),
      .wr_addr         (wr_addr),
      .wr_data         (wr_data),
      .entries_written (entries_written),
      .overflow        (overflow),
      .done            (done)
   );

   // Memory model filled from the write port
   always @(negedge clk) begin
      if (rst_n && wr_en) begin
         mem[wr_addr] <= wr_data;
         wr_cnt       <= wr_cnt + 1;
         last_wr_addr <= wr_addr;
      end
   end

   function automatic logic [95:0] ent(input logic [39:0] xs, input logic [39:0] xe);
      ent = {15'd0, 1'b1, xe, xs};
   endfunction

   task automatic do_reset();
      in_valid = 1'b0;
      rst_n    = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic send(input logic [39:0] lo, input logic [39:0] hi, input logic last,
                       input bit keep);
      bit ok;
      @(negedge clk);
      in_lo = lo; in_hi = hi; in_last = last; in_valid = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 2500 && !ok; i++) begin
         if (in_ready) begin
            @(posedge clk);
            ok = 1'b1;
         end else begin
            @(negedge clk);
         end
      end
      #1;
      if (!keep) in_valid = 1'b0;
      vectors++;
      if (!ok) begin
         miscompares++;
         $display("FAIL handshake lo=%0d: in_ready never seen, got 0 want 1", lo);
      end
   endtask

   task automatic wait_done(input int budget);
      int n;
      n = 0;
      while (!done && n < budget) begin
         @(negedge clk);
         n++;
      end
      vectors++;
      if (done !== 1'b1) begin
         miscompares++;
         $display("FAIL done_timeout: got %b want 1 after %0d cycles", done, budget);
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #1;
      vectors++;
      if ({in_ready, wr_en, wr_addr, wr_data, entries_written, overflow, done} !== '0) begin
         miscompares++;
         $display("FAIL reset_outputs: got rdy=%b we=%b a=%0d d=%h n=%0d ov=%b dn=%b want all 0",
                  in_ready, wr_en, wr_addr, wr_data, entries_written, overflow, done);
      end
      do_reset();
      vectors++;
      if (in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_ready: got %b want 1", in_ready);
      end
   endtask

   task automatic test_single();
      int base;
      bit bad;
      do_reset();
      base = wr_cnt;
      send(40'd11, 40'd22, 1'b1, 1'b0);
      repeat (1020) @(negedge clk);
      vectors++;
      if (wr_en !== 1'b1 || wr_addr !== 10'd11 || done !== 1'b0) begin
         miscompares++;
         $display("FAIL single_last_write: got we=%b a=%0d dn=%b want we=1 a=11 dn=0",
                  wr_en, wr_addr, done);
      end
      @(negedge clk);
      vectors++;
      if (done !== 1'b1 || entries_written !== 10'd12 || in_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL single_done: got dn=%b n=%0d rdy=%b want dn=1 n=12 rdy=0",
                  done, entries_written, in_ready);
      end
      vectors++;
      if (mem[0] !== ent(40'd1, 40'd2)) begin
         miscompares++;
         $display("FAIL single_addr0: got %h want %h", mem[0], ent(40'd1, 40'd2));
      end
      bad = 1'b0;
      for (int a = 1; a < 12; a++) if (mem[a] !== 96'd0) bad = 1'b1;
      vectors++;
      if (bad || (wr_cnt - base) != 12) begin
         miscompares++;
         $display("FAIL single_rest: got nonzero=%b writes=%0d want nonzero=0 writes=12",
                  bad, wr_cnt - base);
      end
   endtask

   task automatic test_clamp();
      do_reset();
      send(40'd95, 40'd115, 1'b1, 1'b0);
      wait_done(1200);
      vectors++;
      if (mem[0] !== ent(40'd9, 40'd9)) begin
         miscompares++;
         $display("FAIL clamp_addr0: got %h want %h", mem[0], ent(40'd9, 40'd9));
      end
      vectors++;
      if (mem[1] !== 96'd0) begin
         miscompares++;
         $display("FAIL clamp_addr1: got %h want 0", mem[1]);
      end
   endtask

   task automatic test_back_to_back();
      int base;
      do_reset();
      base = wr_cnt;
      send(40'd998, 40'd1012, 1'b0, 1'b0);
      send(40'd11, 40'd22, 1'b1, 1'b0);
      wait_done(1200);
      vectors++;
      if (mem[0] !== 96'd0 || mem[1] !== ent(40'd10, 40'd10)) begin
         miscompares++;
         $display("FAIL b2b_range0: got a0=%h a1=%h want a0=0 a1=%h",
                  mem[0], mem[1], ent(40'd10, 40'd10));
      end
      vectors++;
      if (mem[12] !== ent(40'd1, 40'd2)) begin
         miscompares++;
         $display("FAIL b2b_addr12: got %h want %h", mem[12], ent(40'd1, 40'd2));
      end
      vectors++;
      if (entries_written !== 10'd24 || (wr_cnt - base) != 24) begin
         miscompares++;
         $display("FAIL b2b_count: got n=%0d writes=%0d want 24", entries_written, wr_cnt - base);
      end
   endtask

   task automatic test_inverted();
      int base;
      int ready_seen;
      int nonzero;
      int n;
      do_reset();
      base = wr_cnt;
      send(40'd50, 40'd40, 1'b1, 1'b1);
      ready_seen = 0;
      nonzero = 0;
      n = 0;
      while (!done && n < 1200) begin
         @(negedge clk);
         if (in_ready) ready_seen++;
         if (wr_en && wr_data !== 96'd0) nonzero++;
         n++;
      end
      in_valid = 1'b0;
      @(negedge clk);
      vectors++;
      if (ready_seen != 0) begin
         miscompares++;
         $display("FAIL inv_ready: got %0d ready cycles want 0", ready_seen);
      end
      vectors++;
      if (nonzero != 0 || (wr_cnt - base) != 12 || done !== 1'b1) begin
         miscompares++;
         $display("FAIL inv_writes: got nonzero=%0d writes=%0d dn=%b want 0 12 1",
                  nonzero, wr_cnt - base, done);
      end
   endtask

   task automatic test_overflow();
      int base;
      int n;
      do_reset();
      base = wr_cnt;
      for (int r = 0; r < 39; r++) send(40'd11, 40'd22, 1'b0, 1'b0);
      n = 0;
      while (entries_written != 10'd468 && n < 1200) begin
         @(negedge clk);
         n++;
      end
      repeat (3) @(negedge clk);
      vectors++;
      if (overflow !== 1'b0 || in_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL ovf_pre: got ov=%b rdy=%b want 0 0", overflow, in_ready);
      end
      in_lo = 40'd11; in_hi = 40'd22; in_last = 1'b1; in_valid = 1'b1;
      repeat (5) @(negedge clk);
      vectors++;
      if (overflow !== 1'b1 || in_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL ovf_flag: got ov=%b rdy=%b want 1 0", overflow, in_ready);
      end
      in_valid = 1'b0;
      @(negedge clk);
      vectors++;
      if (entries_written !== 10'd468 || (wr_cnt - base) != 468 || done !== 1'b0) begin
         miscompares++;
         $display("FAIL ovf_count: got n=%0d writes=%0d dn=%b want 468 468 0",
                  entries_written, wr_cnt - base, done);
      end
      vectors++;
      if (mem[456] !== ent(40'd1, 40'd2) || mem[467] !== 96'd0) begin
         miscompares++;
         $display("FAIL ovf_last_range: got a456=%h a467=%h want %h 0",
                  mem[456], mem[467], ent(40'd1, 40'd2));
      end
   endtask

   task automatic test_reset_mid();
      int base;
      do_reset();
      send(40'd11, 40'd22, 1'b1, 1'b0);
      repeat (150) @(negedge clk);
      vectors++;
      if (entries_written !== 10'd1 || wr_addr !== 10'd1) begin
         miscompares++;
         $display("FAIL mid_progress: got n=%0d a=%0d want 1 1", entries_written, wr_addr);
      end
      rst_n = 1'b0;
      #1;
      vectors++;
      if ({in_ready, wr_en, wr_addr, wr_data, entries_written, overflow, done} !== '0) begin
         miscompares++;
         $display("FAIL mid_reset_outputs: got rdy=%b we=%b a=%0d d=%h n=%0d ov=%b dn=%b want all 0",
                  in_ready, wr_en, wr_addr, wr_data, entries_written, overflow, done);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      base = wr_cnt;
      send(40'd11, 40'd22, 1'b1, 1'b0);
      wait_done(1200);
      vectors++;
      if (entries_written !== 10'd12 || (wr_cnt - base) != 12 || last_wr_addr !== 10'd11) begin
         miscompares++;
         $display("FAIL mid_rerun_count: got n=%0d writes=%0d last_a=%0d want 12 12 11",
                  entries_written, wr_cnt - base, last_wr_addr);
      end
      vectors++;
      if (mem[0] !== ent(40'd1, 40'd2)) begin
         miscompares++;
         $display("FAIL mid_rerun_addr0: got %h want %h", mem[0], ent(40'd1, 40'd2));
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_clamp();
      test_back_to_back();
      test_inverted();
      test_overflow();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/division_rom_writer.md
Name: division_rom_writer

Overview:
- Builds the per-(range, K) division table that the solver consumes.
- Accepts input ID ranges over a valid/ready stream. For each range and each K in 1..K_MAX it computes the bounds of the repeated-half multiplier x, where ID = x·(10^K+1) and x is clamped to K digits.
- Writes one 96-bit entry per (range, K) into the division memory through a simple write port.
- Replaces the offline hex-file generation step, so new inputs can load at run time.

Parameters:
- ENTRY_COUNT, 468, memory depth; max ranges = ENTRY_COUNT/K_MAX.
- K_MAX, 12, half-length values per range; fixed at 12 (constant table sized for it).
- ADDR_W, 10, write address width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  range present
- in_ready  out  1  block accepts range this cycle
- in_lo  in  40  range low bound, inclusive
- in_hi  in  40  range high bound, inclusive
- in_last  in  1  final range of the input set
- wr_en  out  1  one-cycle memory write strobe
- wr_addr  out  ADDR_W  entry index
- wr_data  out  96  [39:0] x_start, [79:40] x_end, [80] valid, [95:81] zero
- entries_written  out  ADDR_W  count of writes issued
- overflow  out  1  sticky; a range was offered when the table was full
- done  out  1  level; last range fully written

Behaviour:
- Reset (async on rst_n low, all outputs):
  - in_ready=0, wr_en=0, wr_addr=0, wr_data=0, entries_written=0, overflow=0, done=0.
  - FSM returns to S_IDLE; any in-flight division is abandoned and nothing further is written.
- Handshake:
  - Transfer occurs when in_valid && in_ready. in_lo, in_hi and in_last are captured on transfer.
  - in_ready=1 only in S_IDLE with done=0 and entries_written+K_MAX ≤ ENTRY_COUNT.
- FSM states:
  - S_IDLE: wait for transfer; on transfer set K=1 and go to S_SETUP.
  - S_SETUP: c = 10^K+1 (41-bit, from constant table); lo_min = 10^(K-1); hi_max = 10^K−1. Start divider on in_lo/c. Go to S_DIV_LO.
  - S_DIV_LO: wait for div_done. Latch q_lo = quotient + (remainder≠0), i.e. the ceiling. Start in_hi/c. Go to S_DIV_HI.
  - S_DIV_HI: wait for div_done. q_hi = quotient, i.e. the floor. Go to S_CLAMP.
  - S_CLAMP: x_start = max(q_lo, lo_min); x_end = min(q_hi, hi_max); valid = (x_start ≤ x_end). Go to S_WRITE.
  - S_WRITE: wr_en=1 for one cycle. wr_data = valid ? {15'b0,1,x_end,x_start} : 96'b0. Increment wr_addr and entries_written after the write. If K<K_MAX: K+1 → S_SETUP. Else if the captured last flag is set: done=1 → S_DONE. Else → S_IDLE.
  - S_DONE: hold; in_ready=0; only reset exits.
- Addressing: entry for range r, K = r·12 + (K−1); a sequential counter produces this.
- Arithmetic:
  - Dividend 40-bit, divisor 41-bit, quotient 40-bit, remainder 41-bit.
  - Ceiling increment cannot overflow, because lo < 2^40 and c ≥ 11.
  - All comparisons are unsigned 40-bit.
- Latency: divider 41 cycles (1 start + 40 iterations). Each K takes 1+41+41+1+1 = 85 cycles. One range takes 1020 cycles from transfer to the last write.
- Boundaries:
  - in_lo > in_hi: all 12 entries are written with valid=0.
  - in_lo = 0: ceiling is 0, clamped up to lo_min.
  - Offer when full: if in_valid is high in S_IDLE while the full condition holds, set overflow=1 and keep in_ready=0; no write occurs.
  - in_valid ignored outside S_IDLE.

Decomposition:
- Shared package:
  - Entry field offsets (XS_LSB=0, XE_LSB=40, VALID_BIT=80).
  - K_MAX.
  - The const_k table 10^K+1 and the pow10 table (10^0..10^12), shared with the solver's const_k lookup.
- Sub-module div40_seq: restoring radix-2 divider.
  - Ports: start, dividend[39:0], divisor[40:0] → quotient, remainder, div_done (one-cycle pulse).
  - Same clk/rst_n.

Test Plan:
- Range 11–22, last=1 → addr0 = {valid=1, x_start=1, x_end=2}; addr1..11 valid=0 and data zero; done=1 and entries_written=12 after 1020 cycles.
- Range 95–115 → addr0: x_start=9, x_end=9, valid=1 (q_lo=9, q_hi=10 clamped to 9); addr1: valid=0.
- Range 998–1012 then 11–22 (last) → addr0 valid=0 (ceil=91 > 9); addr1 x=10..10 valid=1; second range's K=1 entry at addr12 = {1, x_start=1, x_end=2}; done after 24 writes.
- Range lo=50, hi=40 → 12 writes, all wr_data=0; in_valid held high during processing sees in_ready=0 throughout.
- Fill with 39 ranges, then offer a 40th → overflow=1, in_ready stays 0, entries_written=468.
- Assert rst_n low mid-S_DIV_HI → all outputs return to reset values immediately; after release, range 11–22 re-runs from addr0.
